// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four clients and the rr_arbiter4 round-robin arbiter.
// req is a level per client; the arbiter answers with a registered one-hot gnt, its index and a valid flag.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with a bounded hold time per grant.
// All outputs come from registers (or a pure decode of them); req never reaches an output combinationally.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave arb,
  output logic         dbg_state
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Handshake: a client raises req[i] and keeps it high while it wants the
  // resource; it owns the resource in every cycle where gnt[i]=1. Dropping req
  // releases the grant at the next edge; holding it past MAX_HOLD forces release.

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [2:0] pick_idle;
  logic [2:0] pick_next;
  logic       owner_req;
  logic       expired;
  logic       release_now;

  // Returns {found, index}: first requester at or after start, wrapping mod 4.
  function automatic logic [2:0] pick(input logic [1:0] start, input logic [3:0] r);
    logic [2:0] res;
    logic [1:0] i;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      i = start + 2'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  always_comb begin
    pick_idle   = pick(ptr_q, arb.req);
    pick_next   = pick(gnt_idx_q + 2'd1, arb.req);
    owner_req   = arb.req[gnt_idx_q];
    expired     = (hold_cnt_q == HOLD_LAST);
    release_now = !owner_req || expired;

    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_idx_d  = gnt_idx_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d    = GRANT;
          gnt_idx_d  = pick_idle[1:0];
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d     = gnt_idx_q + 2'd1;
          // Only a still-requesting owner at expiry counts as a forced release.
          timeout_d = owner_req && expired;
          if (pick_next[2]) begin
            gnt_idx_d  = pick_next[1:0];
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_idx_q  <= 2'd0;
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign arb.gnt_valid = (state_q == GRANT);
  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt       = (state_q == GRANT) ? (4'b0001 << gnt_idx_q) : 4'b0000;
  assign arb.timeout   = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: table of single-cycle vectors plus hand-written multi-cycle sequences,
// checked through an expected-value queue.
module tb_rr_arbiter4;

  logic clk;
  logic rst_n;
  logic dbg_state;

  rr_arbiter4_if arb_if ();

  rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb       (arb_if.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // expected word: [7:4] gnt, [3] valid, [2] timeout, [1:0] idx
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       valid;
    logic       tmo;
    logic [1:0] idx;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                         input logic valid, input logic tmo, input logic [1:0] idx,
                         input string name);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.valid = valid; v.tmo = tmo; v.idx = idx; v.name = name;
    vecs.push_back(v);
  endtask

  // scoreboard compare: idx only matters while valid
  task automatic check(input string name);
    logic [7:0] e;
    logic [7:0] a;
    logic       bad;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected queue empty", name);
      return;
    end
    e = exp_q.pop_front();
    a = {arb_if.gnt, arb_if.gnt_valid, arb_if.timeout, arb_if.gnt_idx};
    bad = (a[7:2] !== e[7:2]) || (e[3] && (a[1:0] !== e[1:0]));
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b valid=%b tmo=%b idx=%0d, expected gnt=%b valid=%b tmo=%b idx=%0d",
               name, a[7:4], a[3], a[2], a[1:0], e[7:4], e[3], e[2], e[1:0]);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    arb_if.req = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic v,
                      input logic t, input logic [1:0] i, input string name);
    arb_if.req = r;
    exp_q.push_back({g, v, t, i});
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    int owner;
    logic tmo;

    rst_n = 1'b0;
    arb_if.req = 4'b0000;

    // single client
    add_vec(1, 4'b0100, 4'b0100, 1, 0, 2, "single_c1");
    add_vec(0, 4'b0100, 4'b0100, 1, 0, 2, "single_c2");
    add_vec(0, 4'b0100, 4'b0100, 1, 0, 2, "single_c3");
    add_vec(0, 4'b0000, 4'b0000, 0, 0, 0, "single_rel");
    // handover and skip
    add_vec(1, 4'b1010, 4'b0010, 1, 0, 1, "skip_g1");
    add_vec(0, 4'b1010, 4'b0010, 1, 0, 1, "skip_hold1");
    add_vec(0, 4'b1010, 4'b0010, 1, 0, 1, "skip_hold2");
    add_vec(0, 4'b1000, 4'b1000, 1, 0, 3, "handover_3");
    add_vec(0, 4'b1000, 4'b1000, 1, 0, 3, "hold_3");
    add_vec(0, 4'b0000, 4'b0000, 0, 0, 0, "drop_3_idle");
    // pointer wrapped to 0 after owner 3
    add_vec(0, 4'b0001, 4'b0001, 1, 0, 0, "wrap_g0");
    add_vec(0, 4'b0000, 4'b0000, 0, 0, 0, "wrap_idle");
    // pointer now 1: client 1 wins, client 0 waits without preempting
    add_vec(0, 4'b0011, 4'b0010, 1, 0, 1, "ptr1_g1");
    add_vec(0, 4'b0011, 4'b0010, 1, 0, 1, "no_preempt");
    add_vec(0, 4'b0001, 4'b0001, 1, 0, 0, "wrap_handover_0");
    add_vec(0, 4'b0000, 4'b0000, 0, 0, 0, "final_idle");

    // reset state
    @(posedge clk);
    #1;
    exp_q.push_back(8'b0000_0_0_00);
    check("reset_state");
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      step(vecs[k].req, vecs[k].gnt, vecs[k].valid, vecs[k].tmo, vecs[k].idx, vecs[k].name);
    end

    // fair rotation with all clients requesting
    do_reset();
    for (int t = 0; t < 40; t++) begin
      owner = (t / 8) % 4;
      tmo   = (t >= 8) && (t % 8 == 0);
      step(4'b1111, 4'b0001 << owner, 1'b1, tmo, 2'(owner), $sformatf("rotate_t%0d", t));
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "rotate_end");

    // sole requester re-granted at each timeout
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tmo = (t == 8) || (t == 16);
      step(4'b0001, 4'b0001, 1'b1, tmo, 2'd0, $sformatf("sole_t%0d", t));
    end
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "sole_end");

    // owner drops in the very cycle its count expires
    do_reset();
    for (int t = 0; t < 8; t++)
      step(4'b0101, 4'b0001, 1'b1, 1'b0, 2'd0, $sformatf("simdrop_t%0d", t));
    step(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, "simdrop_handover");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "simdrop_end");

    // asynchronous reset in the middle of a grant
    do_reset();
    step(4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, "midrst_grant");
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(8'b0000_0_0_00);
    check("midrst_async_clear");
    @(posedge clk);
    #1;
    arb_if.req = 4'b0000;
    rst_n = 1'b1;
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, "after_rst_g0");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, "after_rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
